// File: rtl/dht11_disp_fmt.sv
// DHT11 frame checker and ASCII formatter for the LCD status line.
// Optional macro DHT11_RANGE_CHK_EN adds a humidity/temperature plausibility check.
module dht11_disp_fmt #(
   parameter int unsigned TIMEOUT_CYC = 150_000_000
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic [39:0] frame_data,
   output logic        frame_ready,
   output logic [23:0] humi_int_asc,
   output logic [7:0]  humi_dec_asc,
   output logic [23:0] temp_int_asc,
   output logic [7:0]  temp_dec_asc,
   output logic [7:0]  status_chr,
   output logic        disp_valid,
   output logic [7:0]  err_cnt
);
   localparam int              TO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      DASH   = 8'h2D;

   typedef enum logic [1:0] {IDLE, CHECK, CONV, PUBLISH} state_t;

   state_t          state_q;
   logic [39:0]     frame_q;
   logic            err_q;
   logic [7:0]      err_chr_q;
   logic [4:0]      cnt_q;
   logic [11:0]     bcd_q, bcd_d;
   logic [11:0]     hi_bcd_q, ti_bcd_q;
   logic [3:0]      hd_bcd_q, td_bcd_q;
   logic [TO_W-1:0] to_q, to_d;
   logic [7:0]      csum;
   logic            range_bad, good_pub, to_hit;

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
   function automatic logic [11:0] dabble_step(input logic [11:0] v, input logic b);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
      end
      return {r[10:0], b};
   endfunction

   function automatic logic [7:0] asc(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   assign frame_ready = (state_q == IDLE);
   assign csum        = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
   assign bcd_d       = dabble_step(bcd_q, frame_q[39]);
   assign good_pub    = (state_q == PUBLISH) && !err_q;
   assign to_hit      = !good_pub && (to_q == TO_PRE);

`ifdef DHT11_RANGE_CHK_EN
   assign range_bad = (frame_q[39:32] > 8'd100) || (frame_q[23:16] > 8'd60);
`else
   assign range_bad = 1'b0;
`endif

   always_comb begin
      to_d = to_q + TO_W'(1);
      if (good_pub)            to_d = '0;
      else if (to_q == TO_MAX) to_d = to_q;
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         frame_q      <= '0;
         err_q        <= 1'b0;
         err_chr_q    <= '0;
         cnt_q        <= '0;
         bcd_q        <= '0;
         hi_bcd_q     <= '0;
         hd_bcd_q     <= '0;
         ti_bcd_q     <= '0;
         td_bcd_q     <= '0;
         to_q         <= '0;
         humi_int_asc <= {3{DASH}};
         humi_dec_asc <= DASH;
         temp_int_asc <= {3{DASH}};
         temp_dec_asc <= DASH;
         status_chr   <= DASH;
         disp_valid   <= 1'b0;
         err_cnt      <= '0;
      end else begin
         disp_valid <= 1'b0;
         to_q       <= to_d;
         case (state_q)
            IDLE: begin
               if (frame_valid) begin
                  frame_q <= frame_data;
                  err_q   <= 1'b0;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               cnt_q <= '0;
               bcd_q <= '0;
               if (csum != frame_q[7:0]) begin
                  err_q     <= 1'b1;
                  err_chr_q <= "E";
                  state_q   <= PUBLISH;
               end else if (range_bad) begin
                  err_q     <= 1'b1;
                  err_chr_q <= "R";
                  state_q   <= PUBLISH;
               end else begin
                  state_q <= CONV;
               end
            end
            CONV: begin
               // frame_q doubles as the bit source: its MSB feeds the converter each cycle
               frame_q <= {frame_q[38:0], 1'b0};
               cnt_q   <= cnt_q + 5'd1;
               if (cnt_q[2:0] == 3'd7) begin
                  bcd_q <= '0;
                  case (cnt_q[4:3])
                     2'd0:    hi_bcd_q <= bcd_d;
                     2'd1:    hd_bcd_q <= bcd_d[3:0];
                     2'd2:    ti_bcd_q <= bcd_d;
                     default: td_bcd_q <= bcd_d[3:0];
                  endcase
               end else begin
                  bcd_q <= bcd_d;
               end
               if (cnt_q == 5'd31) state_q <= PUBLISH;
            end
            PUBLISH: begin
               disp_valid <= 1'b1;
               state_q    <= IDLE;
               if (err_q) begin
                  status_chr <= err_chr_q;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end else begin
                  humi_int_asc <= {asc(hi_bcd_q[11:8]), asc(hi_bcd_q[7:4]), asc(hi_bcd_q[3:0])};
                  humi_dec_asc <= asc(hd_bcd_q);
                  temp_int_asc <= {asc(ti_bcd_q[11:8]), asc(ti_bcd_q[7:4]), asc(ti_bcd_q[3:0])};
                  temp_dec_asc <= asc(td_bcd_q);
                  status_chr   <= "O";
               end
            end
            default: state_q <= IDLE;
         endcase
         // Timeout overrides an error publish in the same cycle; a good publish never coincides.
         if (to_hit) begin
            humi_int_asc <= {3{DASH}};
            humi_dec_asc <= DASH;
            temp_int_asc <= {3{DASH}};
            temp_dec_asc <= DASH;
            status_chr   <= "T";
            disp_valid   <= 1'b1;
         end
      end
   end
endmodule
